i2c_rtc_target: RTL and testbench

I2C target (slave) that emulates a DS3231M-style register bank at 7-bit address 0x68. It is the bus responder for our I2C initiator: it serves pointer-write, burst-write and random/sequential-read transactions. It is used in loopback benches and on FPGA builds that expose an RTC-compatible register map. A local port lets on-chip logic (e.g. a seconds counter) update and read registers.

---
 rtl/i2c_rtc_target.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_i2c_rtc_target.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rtc_target.sv
//============================================================================
// i2c_rtc_target
//
// I2C target that emulates a DS3231M-style register bank. It answers at a
// 7-bit address (0x68 by default) and supports these transactions:
//   - pointer write
//   - burst write
//   - random and sequential read
// A local port lets on-chip logic write and read the same registers.
//
// Ports
//   sys_clk        system clock
//   rstn           synchronous, active-low reset
//   i2c_scl        bus clock (input only, no clock stretching)
//   i2c_sda        open-drain data, pulled low when this block drives 0
//   i_loc_we       local register write strobe
//   i_loc_addr     local write/read register index
//   i_loc_wdata    local write data
//   o_loc_rdata    register[i_loc_addr], one cycle after the address
//   o_bus_wr_stb   one-cycle pulse per register written over I2C
//   o_bus_wr_addr  register index belonging to o_bus_wr_stb
//   o_bus_wr_data  data belonging to o_bus_wr_stb
//   o_busy         high from address match until STOP, NACK or mismatch
//============================================================================
`timescale 1ns/1ps

module i2c_rtc_target #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         NUM_REGS = 16
) (
    input  logic       sys_clk,
    input  logic       rstn,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic       i_loc_we,
    input  logic [7:0] i_loc_addr,
    input  logic [7:0] i_loc_wdata,
    output logic [7:0] o_loc_rdata,
    output logic       o_bus_wr_stb,
    output logic [7:0] o_bus_wr_addr,
    output logic [7:0] o_bus_wr_data,
    output logic       o_busy
);

    localparam int         IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] REG_CNT = 9'(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

    state_t     state;
    logic [7:0] regs [NUM_REGS];
    logic [7:0] ptr;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       rw;
    logic       ack_phase;
    logic       sda_oe;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       sda_in;
    logic [7:0] byte_in;
    logic       ptr_in_range, loc_in_range;
    logic [7:0] ptr_next;
    logic [7:0] rd_val;
    logic [7:0] loc_rd_val;

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers on both bus lines, then one more flop so we can
    // see edges. The flops reset to 1 because an idle bus is high.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= i2c_scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= i2c_sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // START and STOP need SCL stable high across the SDA edge. That keeps
    // them mutually exclusive with the SCL rise and fall events.
    assign sda_in    = sda_s2;
    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign byte_in   = {shift[6:0], sda_in};

    assign ptr_in_range = ({1'b0, ptr} < REG_CNT);
    assign loc_in_range = ({1'b0, i_loc_addr} < REG_CNT);
    assign ptr_next     = ({1'b0, ptr} >= (REG_CNT - 9'd1)) ? 8'd0 : ptr + 8'd1;

    // Out-of-range pointers read back as zero on both the bus and the local
    // port.
    always_comb begin
        rd_val     = 8'h00;
        loc_rd_val = 8'h00;
        if (ptr_in_range) begin
            rd_val = regs[ptr[IW-1:0]];
        end
        if (loc_in_range) begin
            loc_rd_val = regs[i_loc_addr[IW-1:0]];
        end
    end

    // Protocol FSM and register bank.
    // The local write is coded before the FSM, so a bus write to the same
    // register in the same cycle overrides it. Each ACK state spans two SCL
    // falls:
    //   - the first (end of bit 8) starts driving the ACK;
    //   - the second (end of bit 9) hands over to the next byte.
    // Read bytes are copied into the shift register when the byte starts, so
    // local writes cannot change bits already on the wire.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state         <= IDLE;
            ptr           <= 8'h00;
            shift         <= 8'h00;
            bit_cnt       <= 3'd0;
            rw            <= 1'b0;
            ack_phase     <= 1'b0;
            sda_oe        <= 1'b0;
            o_busy        <= 1'b0;
            o_bus_wr_stb  <= 1'b0;
            o_bus_wr_addr <= 8'h00;
            o_bus_wr_data <= 8'h00;
            o_loc_rdata   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            o_bus_wr_stb <= 1'b0;
            o_loc_rdata  <= loc_rd_val;

            if (i_loc_we && loc_in_range) begin
                regs[i_loc_addr[IW-1:0]] <= i_loc_wdata;
            end

            if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                o_busy    <= 1'b0;
                ack_phase <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw <= sda_in;
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state  <= ADDR_ACK;
                                    o_busy <= 1'b1;
                                end else begin
                                    state  <= IDLE;
                                    sda_oe <= 1'b0;
                                    o_busy <= 1'b0;
                                end
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                if (rw) begin
                                    state  <= RDATA;
                                    shift  <= rd_val;
                                    sda_oe <= ~rd_val[7];
                                end else begin
                                    state  <= PTR;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr   <= byte_in;
                                state <= PTR_ACK;
                            end
                        end
                    end

                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_oe    <= 1'b0;
                                bit_cnt   <= 3'd0;
                                state     <= WDATA;
                            end
                        end
                    end

                    WDATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= WDATA_ACK;
                                // An out-of-range write is still ACKed. It is
                                // dropped without a strobe, and the pointer
                                // stays where it is.
                                if (ptr_in_range) begin
                                    regs[ptr[IW-1:0]] <= byte_in;
                                    o_bus_wr_stb      <= 1'b1;
                                    o_bus_wr_addr     <= ptr;
                                    o_bus_wr_data     <= byte_in;
                                    ptr               <= ptr_next;
                                end
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= RDATA_ACK;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_in) begin
                                state  <= WAIT_STOP;
                                sda_oe <= 1'b0;
                                o_busy <= 1'b0;
                            end else begin
                                ptr       <= ptr_next;
                                ack_phase <= 1'b1;
                            end
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= 3'd0;
                            shift     <= rd_val;
                            sda_oe    <= ~rd_val[7];
                            state     <= RDATA;
                        end
                    end

                    WAIT_STOP: begin
                    end

                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_rtc_target.sv
//============================================================================
// tb_i2c_rtc_target
//
// Directed testbench for i2c_rtc_target. The bench acts as the I2C
// initiator, drives SDA open-drain against a pull-up, and checks bytes, ACKs,
// strobes and local reads against hand-computed values.
//============================================================================
`timescale 1ns/1ps

module tb_i2c_rtc_target;

    localparam int Q = 200;  // quarter of an SCL period, a multiple of sys_clk

    logic       sys_clk = 1'b0;
    logic       rstn;
    logic       i2c_scl;
    logic       tb_sda_oe;
    wire        i2c_sda;
    logic       i_loc_we;
    logic [7:0] i_loc_addr;
    logic [7:0] i_loc_wdata;
    logic [7:0] o_loc_rdata;
    logic       o_bus_wr_stb;
    logic [7:0] o_bus_wr_addr;
    logic [7:0] o_bus_wr_data;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] stb_addr_q [$];
    logic [7:0] stb_data_q [$];

    assign i2c_sda = tb_sda_oe ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_rtc_target dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .i2c_scl       (i2c_scl),
        .i2c_sda       (i2c_sda),
        .i_loc_we      (i_loc_we),
        .i_loc_addr    (i_loc_addr),
        .i_loc_wdata   (i_loc_wdata),
        .o_loc_rdata   (o_loc_rdata),
        .o_bus_wr_stb  (o_bus_wr_stb),
        .o_bus_wr_addr (o_bus_wr_addr),
        .o_bus_wr_data (o_bus_wr_data),
        .o_busy        (o_busy)
    );

    always #10 sys_clk = ~sys_clk;

    // Record every bus-write strobe, sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (o_bus_wr_stb === 1'b1) begin
            stb_addr_q.push_back(o_bus_wr_addr);
            stb_data_q.push_back(o_bus_wr_data);
        end
    end

    // ---------------- bus and local-port primitives ----------------
    task automatic i2c_start();
        tb_sda_oe = 1'b0; #Q;
        i2c_scl = 1'b1;   #Q;
        tb_sda_oe = 1'b1; #Q;
        i2c_scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        tb_sda_oe = 1'b1; #Q;
        i2c_scl = 1'b1;   #Q;
        tb_sda_oe = 1'b0; #Q;
    endtask

    task automatic send_bit(input logic b);
        tb_sda_oe = ~b; #Q;
        i2c_scl = 1'b1; #(2*Q);
        i2c_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        tb_sda_oe = 1'b0; #Q;
        i2c_scl = 1'b1;   #Q;
        nack = i2c_sda;   #Q;
        i2c_scl = 1'b0;   #Q;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        tb_sda_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q; i2c_scl = 1'b1;
            #Q; d[i] = i2c_sda;
            #Q; i2c_scl = 1'b0;
        end
        #Q; tb_sda_oe = ~nack;
        #Q; i2c_scl = 1'b1;
        #(2*Q); i2c_scl = 1'b0;
        #Q; tb_sda_oe = 1'b0;
    endtask

    task automatic read_local(input logic [7:0] a, output logic [7:0] d);
        @(negedge sys_clk);
        i_loc_addr = a;
        @(negedge sys_clk);
        d = o_loc_rdata;
    endtask

    task automatic write_local(input logic [7:0] a, input logic [7:0] d);
        @(negedge sys_clk);
        i_loc_we = 1'b1; i_loc_addr = a; i_loc_wdata = d;
        @(negedge sys_clk);
        i_loc_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        rstn = 1'b0; i2c_scl = 1'b1; tb_sda_oe = 1'b0;
        i_loc_we = 1'b0; i_loc_addr = 8'h00; i_loc_wdata = 8'h00;
        repeat (4) @(negedge sys_clk);
        rstn = 1'b1;
        @(negedge sys_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_bus_wr_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb: got %b expected 0", o_bus_wr_stb); end
        checks++; if (o_bus_wr_addr !== 8'h00 || o_bus_wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_bus: got %h/%h expected 00/00", o_bus_wr_addr, o_bus_wr_data); end
        checks++; if (i2c_sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", i2c_sda); end
        read_local(8'h07, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg7: got %h expected 00", d); end
    endtask

    task automatic test_burst_write();
        logic       n;
        int         nacks = 0;
        logic [7:0] d;
        logic [7:0] exp_d [3] = '{8'h30, 8'h59, 8'h23};
        stb_addr_q.delete(); stb_data_q.delete();
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL bw_busy: got %b expected 1", o_busy); end
        write_byte(8'h00, n); nacks += int'(n);
        for (int i = 0; i < 3; i++) begin write_byte(exp_d[i], n); nacks += int'(n); end
        i2c_stop();
        checks++; if (nacks !== 0) begin errors++; $display("[TB] FAIL bw_acks: got %0d nacks expected 0", nacks); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL bw_busy_stop: got %b expected 0", o_busy); end
        checks++; if (stb_addr_q.size() !== 3) begin errors++; $display("[TB] FAIL bw_stb_count: got %0d expected 3", stb_addr_q.size()); end
        for (int i = 0; i < 3 && i < stb_addr_q.size(); i++) begin
            checks++;
            if (stb_addr_q[i] !== 8'(i) || stb_data_q[i] !== exp_d[i]) begin
                errors++; $display("[TB] FAIL bw_stb%0d: got %h/%h expected %h/%h", i, stb_addr_q[i], stb_data_q[i], 8'(i), exp_d[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            read_local(8'(i), d);
            checks++; if (d !== exp_d[i]) begin errors++; $display("[TB] FAIL bw_reg%0d: got %h expected %h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_random_read();
        logic       n;
        int         nacks = 0;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        write_byte(8'h00, n); nacks += int'(n);
        i2c_start();
        write_byte(8'hD1, n); nacks += int'(n);
        checks++; if (nacks !== 0) begin errors++; $display("[TB] FAIL rr_acks: got %0d nacks expected 0", nacks); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h30) begin errors++; $display("[TB] FAIL rr_byte0: got %h expected 30", d); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h59) begin errors++; $display("[TB] FAIL rr_byte1: got %h expected 59", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h23) begin errors++; $display("[TB] FAIL rr_byte2: got %h expected 23", d); end
        checks++; if (i2c_sda !== 1'b1) begin errors++; $display("[TB] FAIL rr_sda_released: got %b expected 1", i2c_sda); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_busy_nack: got %b expected 0", o_busy); end
        i2c_stop();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_busy_stop: got %b expected 0", o_busy); end
    endtask

    task automatic test_mismatch();
        logic       n;
        logic [7:0] d;
        int         stb_before = stb_addr_q.size();
        i2c_start();
        write_byte(8'hA0, n);
        checks++; if (n !== 1'b1) begin errors++; $display("[TB] FAIL mm_addr_nack: got %b expected 1", n); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL mm_busy: got %b expected 0", o_busy); end
        write_byte(8'h55, n);
        checks++; if (n !== 1'b1) begin errors++; $display("[TB] FAIL mm_data_nack: got %b expected 1", n); end
        i2c_stop();
        checks++; if (stb_addr_q.size() !== stb_before) begin errors++; $display("[TB] FAIL mm_no_stb: got %0d expected %0d", stb_addr_q.size(), stb_before); end
        read_local(8'h00, d);
        checks++; if (d !== 8'h30) begin errors++; $display("[TB] FAIL mm_reg0: got %h expected 30", d); end
    endtask

    task automatic test_wrap_out_of_range();
        logic       n;
        int         nacks = 0;
        logic [7:0] d;
        stb_addr_q.delete(); stb_data_q.delete();
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        write_byte(8'h0F, n); nacks += int'(n);
        write_byte(8'hAA, n); nacks += int'(n);
        write_byte(8'hBB, n); nacks += int'(n);
        i2c_stop();
        checks++; if (stb_addr_q.size() !== 2) begin errors++; $display("[TB] FAIL wr_stb_count: got %0d expected 2", stb_addr_q.size()); end
        if (stb_addr_q.size() >= 2) begin
            checks++; if (stb_addr_q[0] !== 8'h0F || stb_data_q[0] !== 8'hAA) begin errors++; $display("[TB] FAIL wr_stb0: got %h/%h expected 0f/aa", stb_addr_q[0], stb_data_q[0]); end
            checks++; if (stb_addr_q[1] !== 8'h00 || stb_data_q[1] !== 8'hBB) begin errors++; $display("[TB] FAIL wr_stb1: got %h/%h expected 00/bb", stb_addr_q[1], stb_data_q[1]); end
        end
        read_local(8'h0F, d);
        checks++; if (d !== 8'hAA) begin errors++; $display("[TB] FAIL wr_reg15: got %h expected aa", d); end
        read_local(8'h00, d);
        checks++; if (d !== 8'hBB) begin errors++; $display("[TB] FAIL wr_reg0: got %h expected bb", d); end
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        write_byte(8'h20, n); nacks += int'(n);
        write_byte(8'hCC, n); nacks += int'(n);
        i2c_stop();
        checks++; if (nacks !== 0) begin errors++; $display("[TB] FAIL oor_acks: got %0d nacks expected 0", nacks); end
        checks++; if (stb_addr_q.size() !== 2) begin errors++; $display("[TB] FAIL oor_no_stb: got %0d expected 2", stb_addr_q.size()); end
        i2c_start();
        write_byte(8'hD0, n);
        write_byte(8'h20, n);
        i2c_start();
        write_byte(8'hD1, n);
        read_byte(1'b1, d);
        i2c_stop();
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL oor_read: got %h expected 00", d); end
    endtask

    task automatic test_collision();
        logic       n;
        int         nacks = 0;
        logic [7:0] d;
        logic [7:0] bus_byte = 8'h22;
        stb_addr_q.delete(); stb_data_q.delete();
        @(negedge sys_clk);
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        write_byte(8'h01, n); nacks += int'(n);
        for (int i = 7; i >= 1; i--) send_bit(bus_byte[i]);
        // Last data bit: the target commits the byte 50 ns after the SCL pin
        // rises (2 synchronizer flops plus 1 edge flop), so the local strobe
        // is held across that exact edge.
        tb_sda_oe = ~bus_byte[0]; #Q;
        i2c_scl = 1'b1; #40;
        i_loc_we = 1'b1; i_loc_addr = 8'h01; i_loc_wdata = 8'h11; #20;
        i_loc_we = 1'b0; #(2*Q-60);
        i2c_scl = 1'b0; #Q;
        tb_sda_oe = 1'b0; #Q;
        i2c_scl = 1'b1;   #Q;
        nacks += int'(i2c_sda); #Q;
        i2c_scl = 1'b0;   #Q;
        i2c_stop();
        checks++; if (nacks !== 0) begin errors++; $display("[TB] FAIL col_acks: got %0d nacks expected 0", nacks); end
        read_local(8'h01, d);
        checks++; if (d !== 8'h22) begin errors++; $display("[TB] FAIL col_reg1: got %h expected 22", d); end

        // Snapshot: reg5 = 5A, then overwrite it locally in the middle of a read.
        i2c_start();
        write_byte(8'hD0, n); write_byte(8'h05, n); write_byte(8'h5A, n);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, n); write_byte(8'h05, n);
        i2c_start();
        write_byte(8'hD1, n);
        fork
            read_byte(1'b1, d);
            begin #(10*Q); write_local(8'h05, 8'hA5); end
        join
        i2c_stop();
        checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL col_inflight: got %h expected 5a", d); end
        i2c_start();
        write_byte(8'hD0, n); write_byte(8'h05, n);
        i2c_start();
        write_byte(8'hD1, n);
        read_byte(1'b1, d);
        i2c_stop();
        checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL col_next_read: got %h expected a5", d); end
    endtask

    task automatic test_reset_mid_read();
        logic       n;
        int         nacks = 0;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hD0, n); write_byte(8'h03, n); write_byte(8'h0F, n);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, n); write_byte(8'h03, n);
        i2c_start();
        write_byte(8'hD1, n);
        // SCL is low and the target is now presenting bit 7 of 0x0F, a 0.
        checks++; if (i2c_sda !== 1'b0) begin errors++; $display("[TB] FAIL rst_driving: got %b expected 0", i2c_sda); end
        @(negedge sys_clk);
        rstn = 1'b0;
        @(negedge sys_clk);
        checks++; if (i2c_sda !== 1'b1) begin errors++; $display("[TB] FAIL rst_sda_release: got %b expected 1", i2c_sda); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", o_busy); end
        repeat (3) @(negedge sys_clk);
        rstn = 1'b1;
        i2c_scl = 1'b1; #Q;
        for (int i = 0; i < 16; i++) begin
            read_local(8'(i), d);
            checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_reg%0d: got %h expected 00", i, d); end
        end
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        write_byte(8'h02, n); nacks += int'(n);
        write_byte(8'h3C, n); nacks += int'(n);
        write_byte(8'hC3, n); nacks += int'(n);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, n); nacks += int'(n);
        write_byte(8'h02, n); nacks += int'(n);
        i2c_start();
        write_byte(8'hD1, n); nacks += int'(n);
        read_byte(1'b0, d);
        checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL rst_after_b0: got %h expected 3c", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("[TB] FAIL rst_after_b1: got %h expected c3", d); end
        i2c_stop();
        checks++; if (nacks !== 0) begin errors++; $display("[TB] FAIL rst_after_acks: got %0d nacks expected 0", nacks); end
    endtask

    initial begin
        #1_500_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting i2c_rtc_target bench");
        test_reset();
        test_burst_write();
        test_random_read();
        test_mismatch();
        test_wrap_out_of_range();
        test_collision();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
